// File: rtl/cla_seq_ctrl.sv
// Slice-serial add/sub sequencer driving one external CLA slice, LSB slice first.
// Optional zero flag output enabled by defining CLA_SEQ_ZERO_FLAG_EN.
module cla_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
`ifdef CLA_SEQ_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [SLICE-1:0] sl_a,
  output logic [SLICE-1:0] sl_b,
  output logic             sl_cin,
  input  logic [SLICE-1:0] sl_s,
  input  logic             sl_cout
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_n;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_n;
  logic [BW-1:0]    base;
  logic             last;

  assign base = BW'(idx) * BW'(SLICE);
  assign last = (idx == IW'(NSL - 1));

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sl_a      = '0;
    sl_b      = '0;
    sl_cin    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = reset_n;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        sl_a   = a_r[base +: SLICE];
        sl_b   = b_r[base +: SLICE];
        sl_cin = carry;
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Result as it will look after this slice is written back
  always_comb begin
    res_n = result;
    res_n[base +: SLICE] = sl_s;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
`ifdef CLA_SEQ_ZERO_FLAG_EN
      zero     <= 1'b0;
`endif
    end else begin
      if (state == IDLE && in_valid) begin
        a_r   <= op_a;
        b_r   <= op_sub ? ~op_b : op_b;
        carry <= op_sub;
        idx   <= '0;
      end
      if (state == RUN) begin
        result <= res_n;
        carry  <= sl_cout;
        idx    <= idx + 1'b1;
        if (last) begin
          cout     <= sl_cout;
          overflow <= a_r[WIDTH-1] ^ b_r[WIDTH-1]
                    ^ sl_s[SLICE-1] ^ sl_cout;
`ifdef CLA_SEQ_ZERO_FLAG_EN
          zero     <= (res_n == '0);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl with a combinational CLA slice model.
// Directed cases followed by randomized operations against a signed/unsigned arithmetic model.
module tb_cla_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NSL   = WIDTH / SLICE;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             op_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
`ifdef CLA_SEQ_ZERO_FLAG_EN
  logic             zero;
`endif
  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic             sl_cin;
  logic [SLICE-1:0] sl_s;
  logic             sl_cout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // External CLA slice: purely combinational adder
  assign {sl_cout, sl_s} = {1'b0, sl_a} + {1'b0, sl_b} + {8'd0, sl_cin};

  cla_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
`ifdef CLA_SEQ_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .sl_a      (sl_a),
    .sl_b      (sl_b),
    .sl_cin    (sl_cin),
    .sl_s      (sl_s),
    .sl_cout   (sl_cout)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // {overflow, cout, result} from plain integer arithmetic
  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic sub);
    longint sa, sb, sr;
    logic [32:0] u;
    logic c, ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      sr = sa - sb;
      u  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
    end else begin
      sr = sa + sb;
      u  = {1'b0, a} + {1'b0, b};
      c  = u[32];
    end
    ovf = (sr > longint'(2147483647)) || (sr < -longint'(2147483647) - 1);
    return {ovf, c, u[31:0]};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sub);
    op_a = a;
    op_b = b;
    op_sub = sub;
    in_valid = 1'b1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("in_ready_run", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic sub);
    logic [33:0] exp;
    int n;
    exp = model(a, b, sub);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NSL));
    check({tag, "_result"}, 64'(result), 64'(exp[31:0]));
    check({tag, "_cout"}, 64'(cout), 64'(exp[32]));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp[33]));
`ifdef CLA_SEQ_ZERO_FLAG_EN
    check({tag, "_zero"}, 64'(zero), 64'(exp[31:0] == 32'd0));
`endif
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    logic [33:0] e;
    int seen;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout_ovf", 64'({cout, overflow}), 64'd0);
    check("rst_sl", 64'({sl_a, sl_b, sl_cin}), 64'd0);
    reset_n = 1'b1;
    #1;

    // Directed cases
    start_op(32'h000000FF, 32'h00000001, 1'b0);
    wait_done("t1", 32'h000000FF, 32'h00000001, 1'b0);
    check("t1_abs", 64'(result), 64'h100);
    release_op("t1");

    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_done("t2", 32'h7FFFFFFF, 32'h00000001, 1'b0);
    check("t2_ovf_abs", 64'(overflow), 64'd1);
    release_op("t2");

    start_op(32'd5, 32'd7, 1'b1);
    check("t3_sl_cin", 64'(sl_cin), 64'd1);
    check("t3_sl_b", 64'(sl_b), 64'hF8);
    check("t3_sl_a", 64'(sl_a), 64'h05);
    wait_done("t3", 32'd5, 32'd7, 1'b1);
    check("t3_abs", 64'(result), 64'hFFFFFFFE);
    release_op("t3");

    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_done("t4", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    check("t4_cout_abs", 64'(cout), 64'd1);
    release_op("t4");

    // Backpressure with a pending new request
    start_op(32'h00001234, 32'h00000F0F, 1'b1);
    wait_done("t5a", 32'h00001234, 32'h00000F0F, 1'b1);
    e = model(32'h00001234, 32'h00000F0F, 1'b1);
    op_a = 32'hA5A5A5A5;
    op_b = 32'h5A5A5A5A;
    op_sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_result", 64'(result), 64'(e[31:0]));
      check("t5_hold_rdy", 64'(in_ready), 64'd0);
      check("t5_hold_vld", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_idle_rdy", 64'(in_ready), 64'd1);
    check("t5_idle_vld", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    wait_done("t5b", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
    release_op("t5b");

    // Reset mid-operation
    start_op(32'hDEADBEEF, 32'h01020304, 1'b0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_rdy_in_rst", 64'(in_ready), 64'd0);
    tick();
    check("t6_result", 64'(result), 64'd0);
    check("t6_cout_ovf", 64'({cout, overflow}), 64'd0);
    check("t6_vld", 64'(out_valid), 64'd0);
    check("t6_sl", 64'({sl_a, sl_b, sl_cin}), 64'd0);
    reset_n = 1'b1;
    #1;
    check("t6_rdy_after", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("t6_no_vld", 64'(seen), 64'd0);
    start_op(32'h12345678, 32'h11111111, 1'b0);
    wait_done("t6", 32'h12345678, 32'h11111111, 1'b0);
    check("t6_abs", 64'(result), 64'h23456789);
    release_op("t6");

    // Randomized operations with random backpressure
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (k % 6 == 0) rb = ra;
      if (k % 6 == 1) ra = 32'h80000000;
      start_op(ra, rb, rs);
      wait_done("rnd", ra, rb, rs);
      e = model(ra, rb, rs);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        in_valid = 1'b1;
        tick();
        check("rnd_hold", 64'(result), 64'(e[31:0]));
      end
      in_valid = 1'b0;
      release_op("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
